npu_mem_streamer: RTL and testbench
===================================

Name: npu_mem_streamer

Overview:
- Read-side sequencer for one NPU RAM bank (1024x21, single port, synchronous read with 1-cycle latency, active-high write enable).
- Sits directly downstream of the bank: drives its mem_adr/reg_adr/din/we and consumes dout.
- Streams a programmed address range out as a valid/ready word stream to the NPU datapath.
- Arbitrates a host write port onto the same single RAM port.

Parameters:
- DEPTH, 1024: RAM words; address arithmetic is modulo DEPTH.
- WIDTH, 21: data width.
- MEMSEL_W, 6: memory-select field width.
- REGSEL_W, 11: register-address field width.
- MEM_ADDR, 0: bank-select value driven constantly on mem_adr.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  begin transfer; sampled only in IDLE.
- base_adr  in  REGSEL_W  first word address.
- length  in  REGSEL_W  word count; 0 means empty transfer.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  one-cycle pulse on last beat accepted, or on empty transfer.
- m_valid  out  1  stream data valid.
- m_ready  in  1  downstream ready.
- m_data  out  WIDTH  stream data.
- m_last  out  1  marks the final beat.
- host_we  in  1  host write request; always accepted.
- host_adr  in  REGSEL_W  host write address.
- host_din  in  WIDTH  host write data.
- mem_adr  out  MEMSEL_W  constant MEM_ADDR.
- reg_adr  out  REGSEL_W  RAM address.
- din  out  WIDTH  RAM write data.
- we  out  1  RAM write enable, active-high.
- dout  in  WIDTH  RAM read data, valid the cycle after the address.

Behaviour:
- Reset values: busy=0, done=0, m_valid=0, m_last=0, m_data=0, we=0, reg_adr=0, din=0, state=IDLE.
- Reset mid-transfer aborts immediately. Buffered and in-flight data are discarded, and done does not pulse.
- RAM-side outputs are combinational from internal registers and host inputs.
- Host write has absolute priority. In any cycle with host_we=1: we=1, reg_adr=host_adr, din=host_din, and no read is issued that cycle.
- When host_we=0: we=0, and reg_adr is the read pointer when issuing a read, otherwise it holds its last value.
- State IDLE, on start=1:
  - length=0: done pulses the next cycle and the block stays IDLE.
  - Otherwise: latch rd_ptr=base_adr, remaining=length, beats=length, then go to RUN.
- State RUN:
  - Issue a read when host_we=0, remaining>0 and (fifo_count + inflight - pop) < 2.
  - pop = m_valid & m_ready.
  - Each read increments rd_ptr (DEPTH-1 wraps to 0) and decrements remaining.
  - Go to DRAIN when the last read issues.
- State DRAIN: wait until the final beat is accepted, then pulse done and return to IDLE.
- Buffering: a 2-entry output FIFO captures dout in the cycle after each issue (inflight flag).
  - m_data/m_valid come from the FIFO head.
  - m_last=1 on the beat whose index equals beats-1.
- Latency: with start in cycle 0, the read issues in cycle 1, dout is valid in cycle 2, and m_valid first rises in cycle 3.
- Throughput: one beat per cycle with m_ready held high and no host writes.
- Stream rule: m_data and m_last hold stable while m_valid=1 and m_ready=0.
- start while busy is ignored.
- A host write to an address not yet read is visible to the stream. A write to an address already read is not.
- Simultaneous push and pop on the FIFO keeps fifo_count unchanged. The FIFO never overflows by construction, and the bench asserts this.

Optional Feature:
- Macro NPU_STREAM_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt [15:0].
  - Counts cycles with m_valid=1 and m_ready=0, saturating at 16'hFFFF.
  - Cleared by rst and by an accepted start.
  - Holds its value in IDLE.
- Undefined: the port and counter are absent, and all other behaviour is identical.

Test Plan:
- Preload 0..15 via host writes with data=adr*3. Then start with base=4, length=8 and m_ready=1 -> beats 12,15,...,33 on consecutive cycles, first m_valid in cycle 3, m_last on the 8th beat, done one cycle after it.
- Wrap: base=1020, length=8 -> reg_adr sequence 1020..1023,0..3 and data matches the preload.
- Backpressure: toggle m_ready 1,0,0,1 randomly during length=32 -> no loss or duplication, m_data stable while stalled, FIFO count ≤2. With NPU_STREAM_STALL_CNT_EN, stall_cnt equals the stalled cycles.
- Host collision: host_we pulses on 3 cycles mid-transfer, one to a not-yet-read address with 0x1ABCD -> no reads those cycles, we=1 with the host address, and the stream shows 0x1ABCD at that beat.
- length=0 start -> done one cycle later, m_valid never asserts, busy stays 0. start during busy -> ignored.
- rst asserted in cycle 5 of a length=16 transfer -> next cycle all outputs are at reset values and no done. A new start afterwards runs correctly.

Source files
------------

// File: rtl/npu_mem_streamer_if.sv
// Stream and RAM-port bundle for npu_mem_streamer.
// master = streamer side, slave = downstream datapath / RAM bank side.
interface npu_mem_streamer_if #(
  parameter int WIDTH    = 21,
  parameter int MEMSEL_W = 6,
  parameter int REGSEL_W = 11
) ();
  logic                m_valid;
  logic                m_ready;
  logic [WIDTH-1:0]    m_data;
  logic                m_last;
  logic [MEMSEL_W-1:0] mem_adr;
  logic [REGSEL_W-1:0] reg_adr;
  logic [WIDTH-1:0]    din;
  logic                we;
  logic [WIDTH-1:0]    dout;

  modport master (
    output m_valid, m_data, m_last,
    input  m_ready,
    output mem_adr, reg_adr, din, we,
    input  dout
  );

  modport slave (
    input  m_valid, m_data, m_last,
    output m_ready,
    input  mem_adr, reg_adr, din, we,
    output dout
  );
endinterface

// File: rtl/npu_mem_streamer.sv
// Read sequencer for one NPU RAM bank: streams an address range as valid/ready beats,
// host writes take the single RAM port with priority. Optional NPU_STREAM_STALL_CNT_EN adds stall_cnt.
module npu_mem_streamer #(
  parameter int DEPTH    = 1024,
  parameter int WIDTH    = 21,
  parameter int MEMSEL_W = 6,
  parameter int REGSEL_W = 11,
  parameter int MEM_ADDR = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [REGSEL_W-1:0] base_adr,
  input  logic [REGSEL_W-1:0] length,
  output logic                busy,
  output logic                done,
  input  logic                host_we,
  input  logic [REGSEL_W-1:0] host_adr,
  input  logic [WIDTH-1:0]    host_din,
`ifdef NPU_STREAM_STALL_CNT_EN
  output logic [15:0]         stall_cnt,
`endif
  npu_mem_streamer_if.master  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  typedef struct packed {
    logic             last;
    logic [WIDTH-1:0] data;
  } beat_t;

  state_e              state_q, state_d;
  logic [REGSEL_W-1:0] rd_ptr_q, remaining_q, reg_adr_q;
  logic                inflight_q, inflight_last_q;
  beat_t               fifo_q [2];
  logic [1:0]          fifo_cnt;
  logic                wr_idx, rd_idx;
  logic                done_q;
  logic                issue, last_issue, pop, push, start_ok;
  logic [2:0]          occ;

  assign pop      = bus.m_valid & bus.m_ready;
  assign push     = inflight_q;
  assign start_ok = (state_q == IDLE) && start;
  // Occupancy after this cycle's pop, counting the read still in flight from the RAM.
  assign occ        = {1'b0, fifo_cnt} + {2'b0, inflight_q} - {2'b0, pop};
  assign issue      = (state_q == RUN) && !host_we && (remaining_q != '0) && (occ < 3'd2);
  // The last flag rides with the read, so the beat count needs no separate register.
  assign last_issue = issue && (remaining_q == REGSEL_W'(1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    busy        = (state_q != IDLE);
    bus.we      = host_we;
    bus.din     = '0;
    bus.reg_adr = reg_adr_q;
    bus.mem_adr = MEMSEL_W'(MEM_ADDR);
    if (host_we) begin
      bus.reg_adr = host_adr;
      bus.din     = host_din;
    end else if (issue) begin
      bus.reg_adr = rd_ptr_q;
    end
    unique case (state_q)
      IDLE:    if (start && length != '0) state_d = RUN;
      RUN:     if (last_issue) state_d = DRAIN;
      DRAIN:   if (pop && bus.m_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q        <= '0;
      remaining_q     <= '0;
      reg_adr_q       <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      fifo_q[0]       <= '0;
      fifo_q[1]       <= '0;
      fifo_cnt        <= '0;
      wr_idx          <= 1'b0;
      rd_idx          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      done_q <= (start_ok && length == '0) || (state_q == DRAIN && pop && bus.m_last);
      if (start_ok) begin
        rd_ptr_q    <= base_adr;
        remaining_q <= length;
      end else if (issue) begin
        rd_ptr_q    <= (rd_ptr_q == REGSEL_W'(DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
        remaining_q <= remaining_q - 1'b1;
      end
      if (host_we)    reg_adr_q <= host_adr;
      else if (issue) reg_adr_q <= rd_ptr_q;
      inflight_q      <= issue;
      inflight_last_q <= last_issue;
      if (push) begin
        fifo_q[wr_idx] <= {inflight_last_q, bus.dout};
        wr_idx         <= ~wr_idx;
      end
      if (pop) rd_idx <= ~rd_idx;
      fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  assign done        = done_q;
  assign bus.m_valid = (fifo_cnt != '0);
  assign bus.m_data  = fifo_q[rd_idx].data;
  // Gate last so a stale head entry cannot flag once the FIFO drains.
  assign bus.m_last  = bus.m_valid & fifo_q[rd_idx].last;

`ifdef NPU_STREAM_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || start_ok)
      stall_cnt <= '0;
    else if (state_q != IDLE && bus.m_valid && !bus.m_ready && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_npu_mem_streamer.sv
// Directed bench for npu_mem_streamer with a behavioural 1024x21 sync-read RAM.
module tb_npu_mem_streamer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [10:0] base_adr = '0;
  logic [10:0] length = '0;
  logic        busy, done;
  logic        host_we = 1'b0;
  logic [10:0] host_adr = '0;
  logic [20:0] host_din = '0;
`ifdef NPU_STREAM_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  npu_mem_streamer_if #(.WIDTH(21), .MEMSEL_W(6), .REGSEL_W(11)) bus ();

  npu_mem_streamer dut (
    .clk(clk), .rst(rst), .start(start), .base_adr(base_adr), .length(length),
    .busy(busy), .done(done), .host_we(host_we), .host_adr(host_adr), .host_din(host_din),
`ifdef NPU_STREAM_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [20:0] ram [1024];
  always @(posedge clk) begin
    if (bus.we) ram[bus.reg_adr[9:0]] <= bus.din;
    bus.dout <= ram[bus.reg_adr[9:0]];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  logic [20:0] beat_d [$];
  bit          beat_l [$];
  int          beat_c [$];
  int          done_c [$];
  int          adr_q  [$];
  int          last_adr, stall_m, valid_n, busy_n;
  bit          prev_stall;
  logic [21:0] prev_beat;

  task automatic clr();
    beat_d.delete(); beat_l.delete(); beat_c.delete(); done_c.delete(); adr_q.delete();
    last_adr = -1; stall_m = 0; valid_n = 0; busy_n = 0; prev_stall = 1'b0;
  endtask

  // Passive monitor on the falling edge: logs beats, done pulses and issued read addresses.
  always @(negedge clk) begin
    if (prev_stall && !rst)
      chk("stall_hold", {9'b0, bus.m_valid, bus.m_last, bus.m_data}, {9'b0, 1'b1, prev_beat});
    if (bus.m_valid && bus.m_ready) begin
      beat_d.push_back(bus.m_data);
      beat_l.push_back(bus.m_last);
      beat_c.push_back(cyc);
    end
    if (done) done_c.push_back(cyc);
    if (bus.m_valid) valid_n++;
    if (busy) begin
      busy_n++;
      chk("fifo_cnt_le2", {31'b0, dut.fifo_cnt <= 2'd2}, 32'd1);
      if (!bus.we && int'(bus.reg_adr) != last_adr) begin
        last_adr = int'(bus.reg_adr);
        adr_q.push_back(last_adr);
      end
    end
    if (busy && bus.m_valid && !bus.m_ready) stall_m++;
    prev_stall = busy && bus.m_valid && !bus.m_ready;
    prev_beat  = {bus.m_last, bus.m_data};
  end

  function automatic int expd(input int a);
    return ((a % 1024) * 3) & 32'h1FFFFF;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic host_wr(input int a, input int d);
    host_we = 1'b1; host_adr = 11'(a); host_din = 21'(d);
    step();
    host_we = 1'b0;
  endtask

  task automatic run_xfer(input int base, input int len, input logic [15:0] rpat,
                          input int poke, output int t0);
    clr();
    start = 1'b1; base_adr = 11'(base); length = 11'(len); bus.m_ready = rpat[0];
    t0 = cyc;
    step();
    start = 1'b0;
    for (int i = 1; i < 400; i++) begin
      if (done_c.size() > 0) break;
      bus.m_ready = rpat[i % 16];
      if (i == poke) begin start = 1'b1; base_adr = 11'd100; length = 11'd2; end
      step();
      start = 1'b0;
    end
    if (done_c.size() == 0) chk("timeout", 32'd0, 32'd1);
    bus.m_ready = 1'b1;
    step(); step();
  endtask

  task automatic chk_stream(input int base, input int len, input int t0, input bit timed);
    chk("beat_cnt", beat_d.size(), len);
    for (int i = 0; i < len && i < beat_d.size(); i++) begin
      chk("beat_data", beat_d[i], expd(base + i));
      chk("beat_last", {31'b0, beat_l[i]}, {31'b0, i == len - 1});
      if (timed) chk("beat_cyc", beat_c[i] - t0, 3 + i);
    end
    chk("done_cnt", done_c.size(), 1);
    if (timed && done_c.size() > 0) chk("done_cyc", done_c[0] - t0, 3 + len);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_busy"},    {31'b0, busy}, 0);
    chk({tag, "_done"},    {31'b0, done}, 0);
    chk({tag, "_m_valid"}, {31'b0, bus.m_valid}, 0);
    chk({tag, "_m_last"},  {31'b0, bus.m_last}, 0);
    chk({tag, "_m_data"},  {11'b0, bus.m_data}, 0);
    chk({tag, "_we"},      {31'b0, bus.we}, 0);
    chk({tag, "_reg_adr"}, {21'b0, bus.reg_adr}, 0);
    chk({tag, "_din"},     {11'b0, bus.din}, 0);
  endtask

  initial begin
    int t0;
    logic [20:0] exp_d;
    bus.m_ready = 1'b0;
    clr();
    repeat (3) step();
    @(negedge clk);
    chk_reset_outs("rst");
    chk("rst_mem_adr", {26'b0, bus.mem_adr}, 0);
    step();
    rst = 1'b0;
    step();

    for (int a = 0; a < 32; a++) host_wr(a, a * 3);
    for (int a = 1020; a < 1024; a++) host_wr(a, a * 3);

    // Basic stream, full throughput; a start pulse while busy must be ignored.
    run_xfer(4, 8, 16'hFFFF, 4, t0);
    chk_stream(4, 8, t0, 1);
    chk("basic_idle", {31'b0, busy}, 0);

    // Address wrap at the top of the bank.
    run_xfer(1020, 8, 16'hFFFF, -1, t0);
    chk_stream(1020, 8, t0, 1);
    chk("wrap_adr_cnt", adr_q.size(), 8);
    for (int i = 0; i < 8 && i < adr_q.size(); i++) chk("wrap_adr", adr_q[i], (1020 + i) % 1024);

    // Backpressure with an irregular ready pattern.
    run_xfer(0, 32, 16'b1001_0110_0011_1001, -1, t0);
    chk_stream(0, 32, t0, 0);
    chk("bp_stalls_seen", {31'b0, stall_m > 0}, 1);
`ifdef NPU_STREAM_STALL_CNT_EN
    chk("stall_cnt", {16'b0, stall_cnt}, stall_m);
`endif

    // Host collisions mid-transfer: addr 12 not yet read, addr 1 already read.
    clr();
    bus.m_ready = 1'b1;
    start = 1'b1; base_adr = 11'd0; length = 11'd16;
    t0 = cyc;
    step();
    start = 1'b0;
    for (int r = 1; r < 200; r++) begin
      if (done_c.size() > 0) break;
      if (r == 3 || r == 5 || r == 7) begin
        host_we  = 1'b1;
        host_adr = (r == 3) ? 11'd12 : (r == 5) ? 11'd200 : 11'd1;
        host_din = (r == 3) ? 21'h1ABCD : (r == 5) ? 21'd5 : 21'h7777;
        @(negedge clk);
        chk("coll_we",      {31'b0, bus.we}, 1);
        chk("coll_reg_adr", {21'b0, bus.reg_adr}, {21'b0, host_adr});
        chk("coll_din",     {11'b0, bus.din}, {11'b0, host_din});
        step();
        host_we = 1'b0;
      end else begin
        step();
      end
    end
    if (done_c.size() == 0) chk("coll_timeout", 32'd0, 32'd1);
    step(); step();
    chk("coll_beat_cnt", beat_d.size(), 16);
    for (int i = 0; i < 16 && i < beat_d.size(); i++) begin
      exp_d = (i == 12) ? 21'h1ABCD : 21'(i * 3);
      chk("coll_data", {11'b0, beat_d[i]}, {11'b0, exp_d});
    end

    // Empty transfer.
    clr();
    start = 1'b1; base_adr = 11'd5; length = 11'd0;
    step();
    start = 1'b0;
    @(negedge clk);
    chk("len0_done", {31'b0, done}, 1);
    chk("len0_busy", {31'b0, busy}, 0);
    step();
    @(negedge clk);
    chk("len0_done_once", {31'b0, done}, 0);
    repeat (4) step();
    chk("len0_no_valid", valid_n, 0);
    chk("len0_no_busy", busy_n, 0);
    chk("len0_done_cnt", done_c.size(), 1);

    // Reset in cycle 5 of a 16-beat transfer.
    clr();
    start = 1'b1; base_adr = 11'd16; length = 11'd16;
    step();
    start = 1'b0;
    for (int k = 1; k < 5; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outs("mid_rst");
    repeat (6) step();
    chk("mid_rst_no_done", done_c.size(), 0);
    run_xfer(16, 4, 16'hFFFF, -1, t0);
    chk_stream(16, 4, t0, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
